sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single external 8-bit async SRAM bus (21-bit address) between three requesters: the video fetch unit, the ioctl ROM/disk-image download path, and the Next186 CPU/bus interface.
- Sequences every SRAM cycle: address setup, WE_n pulse, read capture, bus turnaround.
- Sits between the core logic and the top-level SRAM pins, in the clk_sys domain.

Parameters:
- ACC_CYCLES, 2, clk_sys cycles the SRAM address/WE_n are held in ACCESS (>=1).
- VID_BURST, 4, max consecutive video grants while cpu_req is pending before the CPU is forced in (>=1).

Ports:
- clk_sys  in  1  system clock (28.636 MHz)
- reset_n  in  1  asynchronous, active-low reset
- vid_req  in  1  video read request, level, held until vid_ack
- vid_addr  in  21  video read address
- vid_ack  out  1  one-cycle pulse, access done
- vid_rdata  out  8  read data, valid with vid_ack, held until next vid_ack
- dl_active  in  1  download in progress; blocks CPU grants
- dl_req  in  1  download write request, level
- dl_addr  in  21  download address
- dl_wdata  in  8  download write data
- dl_ack  out  1  one-cycle pulse, write done
- cpu_req  in  1  CPU request, level
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  21  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle pulse, access done
- cpu_rdata  out  8  read data, valid with cpu_ack, held until next cpu_ack
- sram_a  out  21  SRAM address
- sram_d_out  out  8  SRAM write data
- sram_d_oe  out  1  1=drive SRAM data bus
- sram_d_in  in  8  SRAM read data
- sram_we_n  out  1  SRAM write enable, active low
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, reset_n low): state IDLE, all acks 0, sram_we_n=1, sram_d_oe=0, sram_a=0, sram_d_out=0, rdata regs=0, busy=0, streak counter=0. Mid-access reset aborts immediately; the aborted access is never acked.
- FSM states:
  - IDLE: sample requests.
  - ACCESS: ACC_CYCLES cycles.
  - RECOVER: 1 cycle, then IDLE.
- Grant, evaluated in IDLE only:
  - Default priority is video > download > CPU.
  - Exception: when cpu_req=1, dl_active=0, and streak==VID_BURST, the CPU wins over video.
  - CPU is never granted while dl_active=1.
- Streak counter:
  - +1 (saturating at VID_BURST) on each video grant while cpu_req=1.
  - Cleared on a CPU grant or when cpu_req=0 in IDLE.
- On grant (IDLE→ACCESS edge): latch addr, we, wdata into sram_a/sram_d_out; record the owner. Video is always a read, download always a write.
- ACCESS, write: sram_d_oe=1, sram_we_n=0 for all ACC_CYCLES cycles.
- ACCESS, read: sram_d_oe=0, sram_we_n=1. sram_d_in is captured into the owner's rdata on the last ACCESS cycle.
- ACCESS→RECOVER edge: owner's ack pulses high for exactly the RECOVER cycle.
- RECOVER: sram_we_n=1. sram_a and sram_d_out are held for hold time. sram_d_oe stays at its ACCESS value this cycle, then drops to 0 in IDLE.
- Latency: req sampled at edge E in IDLE → ack high in the cycle after edge E+ACC_CYCLES. Throughput is one access per ACC_CYCLES+2 cycles.
- Requester rules:
  - Keep req and payload stable until ack.
  - Req still high in the cycle after ack is a new request.
  - Requests are never lost or duplicated, because RECOVER ignores requests.
- Simultaneous requests: the lower-priority requester is left pending and keeps req high; there is no timeout.
- dl_active rising while a CPU access is in flight: that access completes and is acked normally.
- busy = (state != IDLE).

Decomposition:
- Shared package (next186_pkg):
  - arbiter state enum {IDLE, ACCESS, RECOVER}
  - owner enum {OWN_VID, OWN_DL, OWN_CPU}
  - SRAM_AW=21, SRAM_DW=8
- One sub-module is natural: sram_arb_pick, the combinational priority/starvation selector taking the reqs, dl_active and streak and returning the owner plus a valid flag.
- The FSM, latches and counters stay in sram_arbiter.

Test Plan:
- Reset, then single CPU read at 0x012345 with the SRAM model returning 0xA5 → sram_a=0x012345 for 2 cycles, we_n never low, cpu_ack in the 3rd cycle after the sampling edge, cpu_rdata=0xA5.
- CPU write of 0x3C to 0x1FFFFF → sram_we_n low exactly 2 cycles, sram_d_out=0x3C, sram_d_oe=1 through RECOVER, one cpu_ack, model mem[0x1FFFFF]=0x3C.
- vid_req held continuously with cpu_req pending, VID_BURST=4 → grant order V,V,V,V,C,V,...; cpu_ack occurs within 5 access slots (20 cycles).
- dl_active=1 with dl_req and cpu_req high → only dl_acks occur; a CPU read is granted on the first IDLE after dl_active falls.
- reset_n low during ACCESS of a write → sram_we_n=1 and sram_d_oe=0 asynchronously, no ack issued; after release, the pending re-request is serviced once.
- vid_req, dl_req and cpu_req all raised in the same cycle → service order video, download, CPU, one ack each, no duplicates.

Source files
------------

// File: rtl/next186_pkg.sv
// Types and widths shared by the Next186 SRAM arbiter.
// Holds the arbiter FSM state and the bus-owner encoding.
package next186_pkg;

   localparam int SRAM_AW = 21;
   localparam int SRAM_DW = 8;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RECOVER
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_VID,
      OWN_DL,
      OWN_CPU
   } owner_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational priority selector for the SRAM arbiter.
// Video > download > CPU, except a starved CPU beats video.
module sram_arb_pick
   import next186_pkg::*;
#(
   parameter int VID_BURST = 4,
   parameter int SW        = 3
) (
   input  logic          vid_req,
   input  logic          dl_req,
   input  logic          cpu_req,
   input  logic          dl_active,
   input  logic [SW-1:0] streak,
   output owner_t        owner,
   output logic          valid
);

   logic cpu_ok;

   assign cpu_ok = cpu_req && !dl_active;

   always_comb begin
      owner = OWN_VID;
      valid = 1'b1;
      if (cpu_ok && (streak == SW'(VID_BURST))) begin
         owner = OWN_CPU;
      end else if (vid_req) begin
         owner = OWN_VID;
      end else if (dl_req) begin
         owner = OWN_DL;
      end else if (cpu_ok) begin
         owner = OWN_CPU;
      end else begin
         valid = 1'b0;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Three-way arbiter and cycle sequencer for the external 8-bit SRAM.
// Each access: IDLE grant, ACC_CYCLES of ACCESS, one RECOVER cycle.
module sram_arbiter
   import next186_pkg::*;
#(
   parameter int ACC_CYCLES = 2,
   parameter int VID_BURST  = 4
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic               vid_req,
   input  logic [SRAM_AW-1:0] vid_addr,
   output logic               vid_ack,
   output logic [SRAM_DW-1:0] vid_rdata,
   input  logic               dl_active,
   input  logic               dl_req,
   input  logic [SRAM_AW-1:0] dl_addr,
   input  logic [SRAM_DW-1:0] dl_wdata,
   output logic               dl_ack,
   input  logic               cpu_req,
   input  logic               cpu_we,
   input  logic [SRAM_AW-1:0] cpu_addr,
   input  logic [SRAM_DW-1:0] cpu_wdata,
   output logic               cpu_ack,
   output logic [SRAM_DW-1:0] cpu_rdata,
   output logic [SRAM_AW-1:0] sram_a,
   output logic [SRAM_DW-1:0] sram_d_out,
   output logic               sram_d_oe,
   input  logic [SRAM_DW-1:0] sram_d_in,
   output logic               sram_we_n,
   output logic               busy
);

   localparam int SW = $clog2(VID_BURST + 1);
   localparam int CW = $clog2(ACC_CYCLES + 1);

   arb_state_t    state_q, state_d;
   owner_t        own_q, pick_own;
   logic          pick_vld;
   logic          we_q;
   logic          last_acc;
   logic [SW-1:0] streak_q;
   logic [CW-1:0] cnt_q;

   sram_arb_pick #(
      .VID_BURST(VID_BURST),
      .SW       (SW)
   ) u_pick (
      .vid_req  (vid_req),
      .dl_req   (dl_req),
      .cpu_req  (cpu_req),
      .dl_active(dl_active),
      .streak   (streak_q),
      .owner    (pick_own),
      .valid    (pick_vld)
   );

   assign last_acc = (state_q == ACCESS) &&
                     (cnt_q == CW'(ACC_CYCLES - 1));

   always_comb begin
      state_d   = state_q;
      sram_we_n = 1'b1;
      sram_d_oe = 1'b0;
      vid_ack   = 1'b0;
      dl_ack    = 1'b0;
      cpu_ack   = 1'b0;
      busy      = (state_q != IDLE);
      unique case (state_q)
         IDLE: begin
            if (pick_vld) state_d = ACCESS;
         end
         ACCESS: begin
            sram_we_n = ~we_q;
            sram_d_oe = we_q;
            if (last_acc) state_d = RECOVER;
         end
         RECOVER: begin
            sram_d_oe = we_q;
            vid_ack   = (own_q == OWN_VID);
            dl_ack    = (own_q == OWN_DL);
            cpu_ack   = (own_q == OWN_CPU);
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         own_q      <= OWN_VID;
         we_q       <= 1'b0;
         cnt_q      <= '0;
         streak_q   <= '0;
         sram_a     <= '0;
         sram_d_out <= '0;
         vid_rdata  <= '0;
         cpu_rdata  <= '0;
      end else begin
         if (state_q == IDLE) begin
            // Starvation streak only counts while the CPU is waiting
            if (!cpu_req || (pick_vld && pick_own == OWN_CPU)) begin
               streak_q <= '0;
            end else if (pick_vld && pick_own == OWN_VID &&
                         streak_q != SW'(VID_BURST)) begin
               streak_q <= streak_q + SW'(1);
            end
            if (pick_vld) begin
               own_q <= pick_own;
               cnt_q <= '0;
               unique case (pick_own)
                  OWN_VID: begin
                     sram_a     <= vid_addr;
                     sram_d_out <= '0;
                     we_q       <= 1'b0;
                  end
                  OWN_DL: begin
                     sram_a     <= dl_addr;
                     sram_d_out <= dl_wdata;
                     we_q       <= 1'b1;
                  end
                  OWN_CPU: begin
                     sram_a     <= cpu_addr;
                     sram_d_out <= cpu_wdata;
                     we_q       <= cpu_we;
                  end
                  default: we_q <= 1'b0;
               endcase
            end
         end
         if (state_q == ACCESS) begin
            cnt_q <= cnt_q + CW'(1);
            if (last_acc && !we_q) begin
               if (own_q == OWN_VID) vid_rdata <= sram_d_in;
               if (own_q == OWN_CPU) cpu_rdata <= sram_d_in;
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async SRAM.
// Each task drives one scenario and checks against hand values.
module tb_sram_arbiter;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        vid_req;
   logic [20:0] vid_addr;
   logic        vid_ack;
   logic [7:0]  vid_rdata;
   logic        dl_active;
   logic        dl_req;
   logic [20:0] dl_addr;
   logic [7:0]  dl_wdata;
   logic        dl_ack;
   logic        cpu_req;
   logic        cpu_we;
   logic [20:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic [20:0] sram_a;
   logic [7:0]  sram_d_out;
   logic        sram_d_oe;
   logic [7:0]  sram_d_in;
   logic        sram_we_n;
   logic        busy;

   int total = 0;
   int bad   = 0;

   logic [7:0] mem [0:(1<<21)-1];
   byte        log_q[$];
   int         we_low = 0;

   localparam byte CH_V = 8'h56;
   localparam byte CH_D = 8'h44;
   localparam byte CH_C = 8'h43;

   sram_arbiter #(
      .ACC_CYCLES(2),
      .VID_BURST (4)
   ) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .vid_req   (vid_req),
      .vid_addr  (vid_addr),
      .vid_ack   (vid_ack),
      .vid_rdata (vid_rdata),
      .dl_active (dl_active),
      .dl_req    (dl_req),
      .dl_addr   (dl_addr),
      .dl_wdata  (dl_wdata),
      .dl_ack    (dl_ack),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ack   (cpu_ack),
      .cpu_rdata (cpu_rdata),
      .sram_a    (sram_a),
      .sram_d_out(sram_d_out),
      .sram_d_oe (sram_d_oe),
      .sram_d_in (sram_d_in),
      .sram_we_n (sram_we_n),
      .busy      (busy)
   );

   always #5 clk_sys = ~clk_sys;

   // Two preloaded read locations, everything else from written memory
   assign sram_d_in = (sram_a == 21'h012345) ? 8'hA5 :
                      (sram_a == 21'h000100) ? 8'h5A :
                      mem[sram_a];

   always @(posedge clk_sys) begin
      if (!sram_we_n) mem[sram_a] <= sram_d_out;
   end

   always @(negedge clk_sys) begin
      if (vid_ack) log_q.push_back(CH_V);
      if (dl_ack)  log_q.push_back(CH_D);
      if (cpu_ack) log_q.push_back(CH_C);
      if (!sram_we_n) we_low = we_low + 1;
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      vid_req   = 1'b0;
      vid_addr  = '0;
      dl_active = 1'b0;
      dl_req    = 1'b0;
      dl_addr   = '0;
      dl_wdata  = '0;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      tick();
      tick();
      total++;
      if ({busy, sram_we_n, sram_d_oe, vid_ack, dl_ack, cpu_ack}
          !== 6'b010000) begin
         bad++;
         $display("FAIL reset_ctl: got %b want 010000",
                  {busy, sram_we_n, sram_d_oe, vid_ack, dl_ack, cpu_ack});
      end
      total++;
      if ({sram_a, sram_d_out, vid_rdata, cpu_rdata} !== 45'd0) begin
         bad++;
         $display("FAIL reset_data: a=%h d=%h vr=%h cr=%h want 0",
                  sram_a, sram_d_out, vid_rdata, cpu_rdata);
      end
      reset_n = 1'b1;
      tick();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle: busy=%b want 0", busy);
      end
   endtask

   task automatic test_cpu_read();
      log_q.delete();
      we_low    = 0;
      cpu_addr  = 21'h012345;
      cpu_we    = 1'b0;
      cpu_req   = 1'b1;
      tick();
      total++;
      if (busy !== 1'b1 || sram_a !== 21'h012345 || cpu_ack !== 1'b0) begin
         bad++;
         $display("FAIL rd_acc1: busy=%b a=%h ack=%b want 1 012345 0",
                  busy, sram_a, cpu_ack);
      end
      tick();
      total++;
      if (sram_a !== 21'h012345 || sram_we_n !== 1'b1 || cpu_ack !== 1'b0) begin
         bad++;
         $display("FAIL rd_acc2: a=%h we_n=%b ack=%b want 012345 1 0",
                  sram_a, sram_we_n, cpu_ack);
      end
      tick();
      total++;
      if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
         bad++;
         $display("FAIL rd_ack: ack=%b rdata=%h want 1 a5", cpu_ack, cpu_rdata);
      end
      cpu_req = 1'b0;
      tick();
      total++;
      if (busy !== 1'b0 || cpu_ack !== 1'b0 || we_low != 0 ||
          log_q.size() != 1) begin
         bad++;
         $display("FAIL rd_end: busy=%b ack=%b we_low=%0d acks=%0d want 0 0 0 1",
                  busy, cpu_ack, we_low, log_q.size());
      end
   endtask

   task automatic test_cpu_write();
      bit found = 1'b0;
      log_q.delete();
      we_low    = 0;
      cpu_addr  = 21'h1FFFFF;
      cpu_wdata = 8'h3C;
      cpu_we    = 1'b1;
      cpu_req   = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (cpu_ack) begin
            found = 1'b1;
            break;
         end
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL wr_timeout: cpu_ack=0 want 1 within 20 cycles");
      end
      total++;
      if (sram_d_oe !== 1'b1 || sram_we_n !== 1'b1 ||
          sram_d_out !== 8'h3C || sram_a !== 21'h1FFFFF) begin
         bad++;
         $display("FAIL wr_recover: oe=%b we_n=%b d=%h a=%h want 1 1 3c 1fffff",
                  sram_d_oe, sram_we_n, sram_d_out, sram_a);
      end
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
      tick();
      total++;
      if (sram_d_oe !== 1'b0) begin
         bad++;
         $display("FAIL wr_oe_idle: oe=%b want 0", sram_d_oe);
      end
      tick();
      total++;
      if (we_low != 2 || log_q.size() != 1 || mem[21'h1FFFFF] !== 8'h3C) begin
         bad++;
         $display("FAIL wr_result: we_low=%0d acks=%0d mem=%h want 2 1 3c",
                  we_low, log_q.size(), mem[21'h1FFFFF]);
      end
   endtask

   task automatic test_vid_burst();
      int cyc    = 0;
      int cpu_at = -1;
      byte exp_q[$] = '{CH_V, CH_V, CH_V, CH_V, CH_C, CH_V};
      log_q.delete();
      vid_addr = 21'h000040;
      cpu_addr = 21'h000041;
      cpu_we   = 1'b0;
      vid_req  = 1'b1;
      cpu_req  = 1'b1;
      for (int i = 0; i < 60; i++) begin
         tick();
         cyc++;
         if (cpu_ack) begin
            cpu_at  = cyc;
            cpu_req = 1'b0;
         end
         if (vid_ack && cpu_at >= 0) begin
            vid_req = 1'b0;
            break;
         end
      end
      vid_req = 1'b0;
      cpu_req = 1'b0;
      tick();
      tick();
      total++;
      if (cpu_at != 19) begin
         bad++;
         $display("FAIL burst_latency: cpu_ack at cycle %0d want 19", cpu_at);
      end
      total++;
      if (log_q != exp_q) begin
         bad++;
         $display("FAIL burst_order: got %p want %p", log_q, exp_q);
      end
   endtask

   task automatic test_dl_block();
      int  n     = 0;
      int  early = 0;
      logic [3:0] acks = '0;
      byte exp_q[$] = '{CH_D, CH_D, CH_D, CH_C};
      log_q.delete();
      dl_active = 1'b1;
      dl_addr   = 21'h000300;
      dl_wdata  = 8'h9E;
      dl_req    = 1'b1;
      cpu_addr  = 21'h000100;
      cpu_we    = 1'b0;
      cpu_req   = 1'b1;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (cpu_ack) early++;
         if (dl_ack) begin
            n++;
            if (n == 3) begin
               dl_req    = 1'b0;
               dl_active = 1'b0;
               break;
            end
         end
      end
      total++;
      if (n != 3 || early != 0) begin
         bad++;
         $display("FAIL dl_phase: dl_acks=%0d cpu_acks=%0d want 3 0", n, early);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         acks[k] = cpu_ack;
      end
      total++;
      if (acks !== 4'b1000 || cpu_rdata !== 8'h5A) begin
         bad++;
         $display("FAIL dl_cpu_after: acks=%b rdata=%h want 1000 5a",
                  acks, cpu_rdata);
      end
      cpu_req = 1'b0;
      tick();
      tick();
      total++;
      if (log_q != exp_q || mem[21'h000300] !== 8'h9E) begin
         bad++;
         $display("FAIL dl_result: log=%p mem=%h want %p 9e",
                  log_q, mem[21'h000300], exp_q);
      end
   endtask

   task automatic test_reset_mid_write();
      bit found = 1'b0;
      log_q.delete();
      cpu_addr  = 21'h000200;
      cpu_wdata = 8'h77;
      cpu_we    = 1'b1;
      cpu_req   = 1'b1;
      tick();
      total++;
      if (sram_we_n !== 1'b0 || sram_d_oe !== 1'b1) begin
         bad++;
         $display("FAIL mid_access: we_n=%b oe=%b want 0 1",
                  sram_we_n, sram_d_oe);
      end
      #2;
      reset_n = 1'b0;
      #1;
      total++;
      if (sram_we_n !== 1'b1 || sram_d_oe !== 1'b0 || busy !== 1'b0 ||
          sram_a !== 21'h0) begin
         bad++;
         $display("FAIL async_abort: we_n=%b oe=%b busy=%b a=%h want 1 0 0 0",
                  sram_we_n, sram_d_oe, busy, sram_a);
      end
      tick();
      tick();
      total++;
      if (log_q.size() != 0) begin
         bad++;
         $display("FAIL abort_ack: acks=%0d want 0", log_q.size());
      end
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (cpu_ack) begin
            found = 1'b1;
            break;
         end
      end
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
      repeat (3) tick();
      total++;
      if (!found || log_q.size() != 1 || mem[21'h000200] !== 8'h77) begin
         bad++;
         $display("FAIL retry_once: found=%b acks=%0d mem=%h want 1 1 77",
                  found, log_q.size(), mem[21'h000200]);
      end
   endtask

   task automatic test_all_three();
      byte exp_q[$] = '{CH_V, CH_D, CH_C};
      log_q.delete();
      vid_addr  = 21'h012345;
      dl_addr   = 21'h000400;
      dl_wdata  = 8'h11;
      cpu_addr  = 21'h000100;
      cpu_we    = 1'b0;
      dl_active = 1'b0;
      vid_req   = 1'b1;
      dl_req    = 1'b1;
      cpu_req   = 1'b1;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (vid_ack) vid_req = 1'b0;
         if (dl_ack)  dl_req  = 1'b0;
         if (cpu_ack) cpu_req = 1'b0;
         if (!vid_req && !dl_req && !cpu_req) break;
      end
      vid_req = 1'b0;
      dl_req  = 1'b0;
      cpu_req = 1'b0;
      repeat (3) tick();
      total++;
      if (log_q != exp_q) begin
         bad++;
         $display("FAIL all3_order: got %p want %p", log_q, exp_q);
      end
      total++;
      if (vid_rdata !== 8'hA5 || cpu_rdata !== 8'h5A ||
          mem[21'h000400] !== 8'h11) begin
         bad++;
         $display("FAIL all3_data: vr=%h cr=%h mem=%h want a5 5a 11",
                  vid_rdata, cpu_rdata, mem[21'h000400]);
      end
   endtask

   initial begin
      test_reset();
      test_cpu_read();
      test_cpu_write();
      test_vid_burst();
      test_dl_block();
      test_reset_mid_write();
      test_all_three();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
